// File: rtl/fft_twiddle_mult_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fft_twiddle_mult_pkg
// Description : Shared helpers for the R2^2 SDF FFT twiddle stage.
//               - clog2       : ceiling log2 for sizing counters/addresses
//               - bitrev2     : 2-bit bit reversal of the quadrant index
//               - twiddle_exp : twiddle exponent e(n, L, s) as a power of W_N
// Revision    : 1.0 - initial release
// ============================================================================
package fft_twiddle_mult_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [1:0] bitrev2(input logic [1:0] q);
        return {q[0], q[1]};
    endfunction

    // e = bitrev2(n / (L/4)) * (n mod (L/4)) * 4^s, with n already reduced mod L.
    // L is a power of 4, so the divide and modulo reduce to bit slicing.
    function automatic int twiddle_exp(input int n, input int blk_len, input int stage);
        int         quarter;
        logic [1:0] q;
        int         r;
        quarter = blk_len / 4;
        q       = 2'(n / quarter);
        r       = n % quarter;
        return int'(bitrev2(q)) * r * (1 << (2 * stage));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_twiddle_rom.sv
`default_nettype none
// ============================================================================
// Module      : fft_twiddle_rom
// Description : Twiddle-factor ROM, W = cos(2*pi*e/N) - j*sin(2*pi*e/N) for
//               e = 0 .. 3N/4-1, rounded to nearest Q1.(TWIDDLE_WIDTH-1) and
//               saturated so +1.0 becomes the largest positive code.
//               Synchronous read, registered output (one cycle latency).
// Ports       : clk_i    - clock
//               addr_i   - exponent e
//               w_re_o   - real part of W_N^e
//               w_im_o   - imaginary part of W_N^e
// Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_rom #(
    parameter int N             = 1024,
    parameter int TWIDDLE_WIDTH = 18,
    parameter int ADDR_W        = 10
) (
    input  logic                            clk_i,
    input  logic [ADDR_W-1:0]               addr_i,
    output logic signed [TWIDDLE_WIDTH-1:0] w_re_o,
    output logic signed [TWIDDLE_WIDTH-1:0] w_im_o
);

    localparam int  ROM_DEPTH = 3 * N / 4;
    localparam real C_PI      = 3.14159265358979323846;
    localparam real C_SCALE   = 2.0 ** (TWIDDLE_WIDTH - 1);

    logic signed [TWIDDLE_WIDTH-1:0] rom_re [ROM_DEPTH];
    logic signed [TWIDDLE_WIDTH-1:0] rom_im [ROM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
        localparam real C_ANG  = 2.0 * C_PI * i / N;
        localparam real C_RE_R = $floor($cos(C_ANG) * C_SCALE + 0.5);
        localparam real C_IM_R = $floor(-$sin(C_ANG) * C_SCALE + 0.5);
        // +1.0 is not representable in Q1.x; clamp to the top code.
        localparam int  C_RE_I = (C_RE_R > C_SCALE - 1.0) ? $rtoi(C_SCALE - 1.0) : $rtoi(C_RE_R);
        localparam int  C_IM_I = (C_IM_R > C_SCALE - 1.0) ? $rtoi(C_SCALE - 1.0) : $rtoi(C_IM_R);
        assign rom_re[i] = TWIDDLE_WIDTH'(C_RE_I);
        assign rom_im[i] = TWIDDLE_WIDTH'(C_IM_I);
    end

    logic signed [TWIDDLE_WIDTH-1:0] w_re_d, w_re_q;
    logic signed [TWIDDLE_WIDTH-1:0] w_im_d, w_im_q;

    always_comb begin
        w_re_d = rom_re[addr_i];
        w_im_d = rom_im[addr_i];
    end

    // No reset so the table can map onto block/distributed ROM.
    always_ff @(posedge clk_i) begin
        w_re_q <= w_re_d;
        w_im_q <= w_im_d;
    end

    assign w_re_o = w_re_q;
    assign w_im_o = w_im_q;

endmodule
`default_nettype wire

// File: rtl/fft_twiddle_mult.sv
`default_nettype none
// ============================================================================
// Module      : fft_twiddle_mult
// Description : R2^2 SDF twiddle rotation stage. Tracks the sample index,
//               looks up W_N^e and rotates each sample through a 4-cycle,
//               never-stalling complex multiplier with round-half-up and
//               saturation back to DATA_WIDTH.
// Ports       : clk_i           - clock
//               rst_n           - asynchronous active-low reset
//               sync_i          - sample is n=0 of a frame (with valid_i)
//               valid_i         - input sample strobe
//               x_re_i, x_im_i  - input sample
//               valid_o         - output sample strobe (valid_i delayed 4)
//               z_re_o, z_im_o  - rotated sample
// Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_mult
    import fft_twiddle_mult_pkg::*;
#(
    parameter int DATA_WIDTH    = 25,
    parameter int TWIDDLE_WIDTH = 18,
    parameter int N             = 1024,
    parameter int STAGE         = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         sync_i,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic                         valid_o,
    output logic signed [DATA_WIDTH-1:0] z_re_o,
    output logic signed [DATA_WIDTH-1:0] z_im_o
);

    localparam int CNT_W   = clog2(N);
    localparam int BLK_L   = N >> (2 * STAGE);
    localparam int ADDR_W  = clog2(3 * N / 4);
    localparam int PROD_W  = DATA_WIDTH + TWIDDLE_WIDTH;
    localparam int SUM_W   = PROD_W + 1;

    localparam logic [CNT_W-1:0]        C_IDX_MASK = CNT_W'(BLK_L - 1);
    localparam logic signed [SUM_W-1:0] C_RND      = SUM_W'(1) <<< (TWIDDLE_WIDTH - 2);
    localparam logic signed [SUM_W-1:0] C_SAT_MAX  = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] C_SAT_MIN  = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Round half-up, drop the Q1.x fraction, clamp to the output range.
    function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] s;
        s = (v + C_RND) >>> (TWIDDLE_WIDTH - 1);
        if (s > C_SAT_MAX)      return C_SAT_MAX[DATA_WIDTH-1:0];
        else if (s < C_SAT_MIN) return C_SAT_MIN[DATA_WIDTH-1:0];
        else                    return s[DATA_WIDTH-1:0];
    endfunction

    // ---------------- index / ROM stage ----------------
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [CNT_W-1:0]  idx;
    logic [ADDR_W-1:0] rom_addr;
    logic signed [TWIDDLE_WIDTH-1:0] w_re, w_im;

    // ---------------- pipeline registers ----------------
    logic                         v1_d, v1_q, v2_d, v2_q, v3_d, v3_q, vo_d, vo_q;
    logic signed [DATA_WIDTH-1:0] x_re1_d, x_re1_q, x_im1_d, x_im1_q;
    logic signed [PROD_W-1:0]     p_rr_d, p_rr_q, p_ii_d, p_ii_q;
    logic signed [PROD_W-1:0]     p_ri_d, p_ri_q, p_ir_d, p_ir_q;
    logic signed [SUM_W-1:0]      s_re_d, s_re_q, s_im_d, s_im_q;
    logic signed [DATA_WIDTH-1:0] z_re_d, z_re_q, z_im_d, z_im_q;

    always_comb begin
        cnt_d = cnt_q;
        if (valid_i) begin
            cnt_d = sync_i ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end
        // A synced sample is index 0 regardless of where the counter sits.
        idx      = (sync_i ? '0 : cnt_q) & C_IDX_MASK;
        rom_addr = ADDR_W'(twiddle_exp(int'(idx), BLK_L, STAGE));

        v1_d    = valid_i;
        x_re1_d = x_re_i;
        x_im1_d = x_im_i;

        v2_d    = v1_q;
        p_rr_d  = PROD_W'(x_re1_q) * PROD_W'(w_re);
        p_ii_d  = PROD_W'(x_im1_q) * PROD_W'(w_im);
        p_ri_d  = PROD_W'(x_re1_q) * PROD_W'(w_im);
        p_ir_d  = PROD_W'(x_im1_q) * PROD_W'(w_re);

        v3_d    = v2_q;
        s_re_d  = SUM_W'(p_rr_q) - SUM_W'(p_ii_q);
        s_im_d  = SUM_W'(p_ri_q) + SUM_W'(p_ir_q);

        vo_d    = v3_q;
        z_re_d  = round_sat(s_re_q);
        z_im_d  = round_sat(s_im_q);
    end

    fft_twiddle_rom #(
        .N             (N),
        .TWIDDLE_WIDTH (TWIDDLE_WIDTH),
        .ADDR_W        (ADDR_W)
    ) u_rom (
        .clk_i  (clk_i),
        .addr_i (rom_addr),
        .w_re_o (w_re),
        .w_im_o (w_im)
    );

    // Control and output registers: cleared immediately on reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            vo_q   <= 1'b0;
            z_re_q <= '0;
            z_im_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            vo_q   <= vo_d;
            z_re_q <= z_re_d;
            z_im_q <= z_im_d;
        end
    end

    // Interior datapath left without reset so it packs into DSP registers;
    // its contents are qualified by the valid bits above.
    always_ff @(posedge clk_i) begin
        x_re1_q <= x_re1_d;
        x_im1_q <= x_im1_d;
        p_rr_q  <= p_rr_d;
        p_ii_q  <= p_ii_d;
        p_ri_q  <= p_ri_d;
        p_ir_q  <= p_ir_d;
        s_re_q  <= s_re_d;
        s_im_q  <= s_im_d;
    end

    assign valid_o = vo_q;
    assign z_re_o  = z_re_q;
    assign z_im_o  = z_im_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_twiddle_mult
// Description : Self-checking bench for fft_twiddle_mult (N=64, STAGE=0).
//               Expected outputs come from a floating-point twiddle model and
//               plain integer complex arithmetic, delayed four cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_twiddle_mult;

    localparam int DW = 25;
    localparam int TW = 18;
    localparam int NN = 64;
    localparam int ST = 0;
    localparam int LL = NN >> (2 * ST);
    localparam longint C_DMAX = (longint'(1) << (DW - 1)) - 1;
    localparam longint C_DMIN = -(longint'(1) << (DW - 1));

    logic clk_i   = 1'b0;
    logic rst_n   = 1'b0;
    logic sync_i  = 1'b0;
    logic valid_i = 1'b0;
    logic signed [DW-1:0] x_re_i = '0;
    logic signed [DW-1:0] x_im_i = '0;
    logic                 valid_o;
    logic signed [DW-1:0] z_re_o;
    logic signed [DW-1:0] z_im_o;

    int n_checks = 0;
    int n_fail   = 0;
    int mcnt     = 0;

    typedef struct {
        bit     v;
        int     n;
        int     kind;   // 0 model only, 1 identity, 2 n=17 rotation, 3 n=40 saturation
        longint xre, xim, zre, zim;
    } exp_t;

    exp_t hist [4];

    fft_twiddle_mult #(
        .DATA_WIDTH    (DW),
        .TWIDDLE_WIDTH (TW),
        .N             (NN),
        .STAGE         (ST)
    ) dut (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .sync_i  (sync_i),
        .valid_i (valid_i),
        .x_re_i  (x_re_i),
        .x_im_i  (x_im_i),
        .valid_o (valid_o),
        .z_re_o  (z_re_o),
        .z_im_o  (z_im_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic longint tw_comp(input real val);
        real s;
        s = $floor(val * (2.0 ** (TW - 1)) + 0.5);
        if (s > (2.0 ** (TW - 1)) - 1.0) s = (2.0 ** (TW - 1)) - 1.0;
        return longint'($rtoi(s));
    endfunction

    function automatic longint scale_sat(input longint p);
        longint r;
        r = (p + (longint'(1) << (TW - 2))) >>> (TW - 1);
        if (r > C_DMAX) r = C_DMAX;
        if (r < C_DMIN) r = C_DMIN;
        return r;
    endfunction

    function automatic longint rnd_data();
        logic signed [DW-1:0] t;
        t = DW'($urandom);
        return longint'(t);
    endfunction

    function automatic longint rnd_small();
        return longint'($urandom_range(60000)) - 30000;
    endfunction

    task automatic clear_model();
        mcnt = 0;
        for (int i = 0; i < 4; i++) begin
            hist[i].v = 0; hist[i].n = 0; hist[i].kind = 0;
            hist[i].xre = 0; hist[i].xim = 0; hist[i].zre = 0; hist[i].zim = 0;
        end
    endtask

    task automatic check_out(input exp_t e);
        longint zr, zi;
        zr = longint'(z_re_o);
        zi = longint'(z_im_o);
        n_checks++;
        assert (valid_o === e.v) else begin
            n_fail++;
            $error("FAIL valid_o (n=%0d): got %b expected %b", e.n, valid_o, e.v);
        end
        if (e.v) begin
            n_checks++;
            assert (zr === e.zre) else begin
                n_fail++;
                $error("FAIL z_re n=%0d x=(%0d,%0d): got %0d expected %0d", e.n, e.xre, e.xim, zr, e.zre);
            end
            n_checks++;
            assert (zi === e.zim) else begin
                n_fail++;
                $error("FAIL z_im n=%0d x=(%0d,%0d): got %0d expected %0d", e.n, e.xre, e.xim, zi, e.zim);
            end
            if (e.kind == 1) begin
                n_checks++;
                assert (zr === e.xre && zi === e.xim) else begin
                    n_fail++;
                    $error("FAIL identity n=%0d: got (%0d,%0d) expected (%0d,%0d)", e.n, zr, zi, e.xre, e.xim);
                end
            end else if (e.kind == 2) begin
                n_checks++;
                assert (zr >= 980 && zr <= 982 && zi >= -196 && zi <= -194) else begin
                    n_fail++;
                    $error("FAIL rot17: got (%0d,%0d) expected (981,-195) +-1", zr, zi);
                end
            end else if (e.kind == 3) begin
                n_checks++;
                assert (zr === C_DMAX && zi >= -1 && zi <= 1) else begin
                    n_fail++;
                    $error("FAIL sat40: got (%0d,%0d) expected (%0d,|im|<=1)", zr, zi, C_DMAX);
                end
            end
        end
    endtask

    // Drive one cycle of input, advance the reference model, then compare the
    // output against the sample entered four cycles earlier.
    task automatic step(input bit v, input bit s, input longint xr, input longint xi, input int kind);
        exp_t e;
        int   q, r, qb, ex;
        real  ang;
        longint wr, wi;
        valid_i = v;
        sync_i  = s;
        x_re_i  = DW'(xr);
        x_im_i  = DW'(xi);
        e.v = v; e.kind = kind; e.xre = xr; e.xim = xi; e.n = 0; e.zre = 0; e.zim = 0;
        if (v) begin
            e.n  = s ? 0 : (mcnt % LL);
            mcnt = s ? 1 : ((mcnt + 1) % NN);
            q    = e.n / (LL / 4);
            r    = e.n % (LL / 4);
            qb   = ((q & 1) << 1) | ((q >> 1) & 1);
            ex   = qb * r * (4 ** ST);
            ang  = 2.0 * 3.14159265358979323846 * ex / NN;
            wr   = tw_comp($cos(ang));
            wi   = tw_comp(-$sin(ang));
            e.zre = scale_sat(xr * wr - xi * wi);
            e.zim = scale_sat(xr * wi + xi * wr);
        end
        @(posedge clk_i);
        #1;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = e;
        check_out(hist[3]);
    endtask

    task automatic check_reset_zero(input string tag);
        n_checks++;
        assert (valid_o === 1'b0 && z_re_o === '0 && z_im_o === '0) else begin
            n_fail++;
            $error("FAIL %s: got valid=%b z=(%0d,%0d) expected 0,(0,0)", tag, valid_o, z_re_o, z_im_o);
        end
    endtask

    initial begin
        clear_model();

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_zero("reset_state");
        #3;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);

        // Frame 1: identity quadrant, rotation at n=17, saturation at n=40,
        // plus a sync without valid that must be ignored.
        step(1, 1, 1000, -500, 1);
        for (int i = 1; i < 16; i++) step(1, 0, 1000, -500, 1);
        step(1, 0, rnd_data(), rnd_data(), 0);
        step(1, 0, 1000, 0, 2);
        for (int i = 18; i < 30; i++) step(1, 0, rnd_data(), rnd_data(), 0);
        step(0, 1, rnd_data(), rnd_data(), 0);
        for (int i = 30; i < 40; i++) step(1, 0, rnd_data(), rnd_data(), 0);
        step(1, 0, C_DMAX, C_DMAX, 3);
        for (int i = 41; i < 64; i++) step(1, 0, rnd_data(), rnd_data(), 0);

        // Gapped frame: valid_i low on every third cycle.
        for (int i = 0; i < 66; i++) step((i % 3) != 2, i == 0, rnd_data(), rnd_data(), 0);

        // Resync at cnt=37: synced sample is n=0, the following one n=1.
        step(1, 1, rnd_data(), rnd_data(), 0);
        for (int i = 1; i < 37; i++) step(1, 0, rnd_data(), rnd_data(), 0);
        step(1, 1, rnd_small(), rnd_small(), 1);
        step(1, 0, rnd_small(), rnd_small(), 1);
        for (int i = 0; i < 8; i++) step(1, 0, rnd_data(), rnd_data(), 0);

        // Reset mid-frame at cnt=20 with the pipeline full.
        step(1, 1, rnd_data(), rnd_data(), 0);
        for (int i = 1; i < 20; i++) step(1, 0, rnd_data(), rnd_data(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_zero("async_reset");
        @(posedge clk_i);
        #1;
        check_reset_zero("reset_held");
        #3;
        rst_n = 1'b1;
        clear_model();
        valid_i = 1'b0;
        sync_i  = 1'b0;
        // First valid after release is index 0 even without sync.
        step(1, 0, rnd_small(), rnd_small(), 1);
        for (int i = 1; i < 24; i++) step(1, 0, rnd_data(), rnd_data(), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
